// File: rtl/neuron_layer_seq_pkg.sv
// Shared types and defaults for the layer sequencer: state encoding and
// default data width / fetch-pipeline latency.
package neuro_seq_pkg;

    localparam int W_DEF        = 16;
    localparam int PIPE_LAT_DEF = 3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DESC_RD  = 3'd1,
        S_DESC_CAP = 3'd2,
        S_LOAD     = 3'd3,
        S_FETCH    = 3'd4,
        S_DRAIN    = 3'd5,
        S_COMMIT   = 3'd6,
        S_DONE     = 3'd7
    } state_e;

    // Width of the drain counter; it only has to hold PIPE_LAT-1.
    function automatic int drain_w(input int lat);
        return (lat > 2) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/neuron_layer_seq_if.sv
// Bundle of the layer-controller, descriptor-ROM, fetch-pipeline and MAC signals
// seen by the sequencer; slave is the sequencer side, master the environment.
interface neuron_layer_seq_if #(
    parameter int W = neuro_seq_pkg::W_DEF
);
    logic         start;
    logic         abort;
    logic [W-1:0] num_neurons;
    logic         busy;
    logic         done;
    logic [W-1:0] desc_addr;
    logic [W-1:0] desc_val;
    logic         pf_load;
    logic [W-1:0] pf_num_adds;
    logic         pf_start_fetch;
    logic [W-1:0] pf_base;
    logic         pf_we;
    logic         mac_clear;
    logic         mac_commit;
    logic [W-1:0] neuron_idx;
    logic         err;

    modport slave (
        input  start, abort, num_neurons, desc_val, pf_we,
        output busy, done, desc_addr, pf_load, pf_num_adds, pf_start_fetch,
               pf_base, mac_clear, mac_commit, neuron_idx, err
    );

    modport master (
        output start, abort, num_neurons, desc_val, pf_we,
        input  busy, done, desc_addr, pf_load, pf_num_adds, pf_start_fetch,
               pf_base, mac_clear, mac_commit, neuron_idx, err
    );
endinterface

// File: rtl/neuron_layer_seq.sv
// Per-layer sequencer: reads each neuron's add count, drives the fetch pipeline,
// waits out its latency and commits the MAC. Optional macro SEQ_WE_CHECK_EN adds a sticky WE-count check.
module neuron_layer_seq
    import neuro_seq_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    neuron_layer_seq_if.slave bus
);

    localparam int DW = drain_w(PIPE_LAT);

    state_e         state_q, state_d;
    logic [W-1:0]   idx_q, idx_d;
    logic [W-1:0]   base_q, base_d;
    logic [W-1:0]   num_q, num_d;
    logic [W-1:0]   n_q, n_d;
    logic [W-1:0]   fcnt_q, fcnt_d;
    logic [DW-1:0]  dcnt_q, dcnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            num_q   <= '0;
            n_q     <= '0;
            fcnt_q  <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            num_q   <= num_d;
            n_q     <= n_d;
            fcnt_q  <= fcnt_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Abort beats everything, so base and index hold their values on abort.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        num_d   = num_q;
        n_d     = n_q;
        fcnt_d  = fcnt_q;
        dcnt_d  = dcnt_q;
        if (bus.abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        num_d = bus.num_neurons;
                        if (bus.num_neurons == '0) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = '0;
                            base_d  = '0;
                            state_d = S_DESC_RD;
                        end
                    end
                end
                S_DESC_RD:  state_d = S_DESC_CAP;
                S_DESC_CAP: begin
                    n_d     = bus.desc_val;
                    state_d = S_LOAD;
                end
                S_LOAD: begin
                    fcnt_d  = n_q;
                    state_d = (n_q == '0) ? S_COMMIT : S_FETCH;
                end
                S_FETCH: begin
                    fcnt_d = fcnt_q - W'(1);
                    dcnt_d = DW'(PIPE_LAT - 1);
                    if (fcnt_q == W'(1)) state_d = S_DRAIN;
                end
                S_DRAIN: begin
                    dcnt_d = dcnt_q - DW'(1);
                    if (dcnt_q == '0) state_d = S_COMMIT;
                end
                S_COMMIT: begin
                    base_d = base_q + n_q;
                    if (idx_q == num_q - W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + W'(1);
                        state_d = S_DESC_RD;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.busy           = (state_q != S_IDLE);
    assign bus.done           = (state_q == S_DONE);
    assign bus.desc_addr      = idx_q;
    assign bus.neuron_idx     = idx_q;
    assign bus.pf_base        = base_q;
    assign bus.pf_num_adds    = n_q;
    assign bus.pf_load        = (state_q == S_LOAD);
    assign bus.mac_clear      = (state_q == S_LOAD);
    assign bus.pf_start_fetch = (state_q == S_FETCH);
    assign bus.mac_commit     = (state_q == S_COMMIT);

`ifdef SEQ_WE_CHECK_EN
    logic [W-1:0] we_cnt_q, we_cnt_d;
    logic         err_q, err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            we_cnt_q <= we_cnt_d;
            err_q    <= err_d;
        end
    end

    // WE pulses are counted in the window after LOAD up to the last DRAIN cycle.
    always_comb begin
        we_cnt_d = we_cnt_q;
        err_d    = err_q;
        if (state_q == S_LOAD) begin
            we_cnt_d = '0;
        end else if ((state_q == S_FETCH || state_q == S_DRAIN) && bus.pf_we) begin
            we_cnt_d = we_cnt_q + W'(1);
        end
        if (!bus.abort) begin
            if (state_q == S_IDLE && bus.start) err_d = 1'b0;
            if (state_q == S_COMMIT && we_cnt_q != n_q) err_d = 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    logic unused_we;
    assign unused_we = bus.pf_we;
    assign bus.err   = 1'b0;
`endif

endmodule

// File: tb/tb_neuron_layer_seq.sv
// Directed bench for neuron_layer_seq with a descriptor-ROM model and a
// PIPE_LAT-deep fetch-pipeline model that can swallow one WE pulse.
module tb_neuron_layer_seq;
    import neuro_seq_pkg::*;

    localparam int W  = 16;
    localparam int PL = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    neuron_layer_seq_if #(.W(W)) bus();
    neuron_layer_seq #(.W(W), .PIPE_LAT(PL)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Descriptor ROM, one-cycle read latency.
    logic [W-1:0] rom [0:7];
    always @(posedge clk) bus.desc_val <= rom[bus.desc_addr[2:0]];

    // Fetch pipeline model: WE comes PL cycles after fetch enable.
    logic [PL-1:0] we_sr      = '0;
    logic          first_q    = 1'b0;
    logic          drop_first = 1'b0;
    always @(posedge clk) begin
        if (bus.pf_load) first_q <= 1'b1;
        else if (bus.pf_start_fetch) first_q <= 1'b0;
        we_sr <= {we_sr[PL-2:0], bus.pf_start_fetch & ~(drop_first & first_q)};
    end
    assign bus.pf_we = we_sr[PL-1];

    logic [4*W+6:0] outs;
    assign outs = {bus.busy, bus.done, bus.desc_addr, bus.pf_load, bus.pf_num_adds,
                   bus.pf_start_fetch, bus.pf_base, bus.mac_clear, bus.mac_commit,
                   bus.neuron_idx, bus.err};

    int n_tests = 0;
    int n_fail  = 0;

    // Observations gathered by run_layer.
    int loads, clears, commits, fetches, fetch_n1, done_cyc, last_fetch, commit_cyc;
    logic [W-1:0] base_at_load[$];
    logic [W-1:0] adds_at_load[$];
    logic [W-1:0] idx_c1, base_c1, ab_idx, ab_base;
    logic err_c1, err_done, ab_pre_fetch, ab_fetch, ab_busy;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Cycle c=1 is the first cycle after the edge that accepts start.
    task automatic run_layer(input logic [W-1:0] num, input int budget,
                             input int poke_c, input int abort_c);
        loads = 0; clears = 0; commits = 0; fetches = 0; fetch_n1 = 0;
        done_cyc = -1; last_fetch = -1; commit_cyc = -1;
        base_at_load.delete(); adds_at_load.delete();
        bus.num_neurons = num;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            if (c == 1) begin
                idx_c1 = bus.neuron_idx; base_c1 = bus.pf_base; err_c1 = bus.err;
            end
            if (c == abort_c) ab_pre_fetch = bus.pf_start_fetch;
            if (c == abort_c + 1) begin
                ab_fetch = bus.pf_start_fetch; ab_busy = bus.busy;
                ab_idx = bus.neuron_idx; ab_base = bus.pf_base;
            end
            if (bus.pf_load) begin
                loads++;
                base_at_load.push_back(bus.pf_base);
                adds_at_load.push_back(bus.pf_num_adds);
            end
            if (bus.mac_clear) clears++;
            if (bus.pf_start_fetch) begin
                fetches++; last_fetch = c;
                if (bus.neuron_idx == 1) fetch_n1++;
            end
            if (bus.mac_commit) begin
                commits++;
                if (commit_cyc < 0) commit_cyc = c;
            end
            if (bus.done) begin
                done_cyc = c; err_done = bus.err;
                break;
            end
            bus.start = (c == poke_c);
            bus.abort = (c == abort_c);
            if (c == poke_c) bus.num_neurons = 3;
            cyc();
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_tests++; if (outs !== '0) begin n_fail++; $display("FAIL reset_outs got %h want 0", outs); end
        rst = 1'b1;
        cyc();
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle busy=%b want 0", bus.busy); end
    endtask

    // One neuron, 4 adds: RD,CAP,LOAD,4xFETCH,3xDRAIN,COMMIT then DONE in cycle 12.
    task automatic test_single();
        rom[0] = 16'd4;
        run_layer(16'd1, 40, -1, -1);
        n_tests++; if (loads !== 1) begin n_fail++; $display("FAIL t1_loads got %0d want 1", loads); end
        n_tests++; if (fetches !== 4) begin n_fail++; $display("FAIL t1_fetches got %0d want 4", fetches); end
        n_tests++; if (commit_cyc - last_fetch !== PL + 1) begin n_fail++; $display("FAIL t1_commit_gap got %0d want %0d", commit_cyc - last_fetch, PL + 1); end
        n_tests++; if (done_cyc !== 12) begin n_fail++; $display("FAIL t1_done_cyc got %0d want 12", done_cyc); end
        n_tests++; if (err_done !== 1'b0) begin n_fail++; $display("FAIL t1_err got %b want 0", err_done); end
        n_tests++; if (bus.pf_base !== 16'd4) begin n_fail++; $display("FAIL t1_base_done got %0d want 4", bus.pf_base); end
        cyc();
        n_tests++; if ({bus.busy, bus.pf_base} !== {1'b0, 16'd4}) begin n_fail++; $display("FAIL t1_after busy=%b base=%0d want 0/4", bus.busy, bus.pf_base); end
    endtask

    // Neurons cost 9, 4 and 12 cycles; DONE lands in cycle 26.
    task automatic test_multi();
        rom[0] = 16'd2; rom[1] = 16'd0; rom[2] = 16'd5;
        run_layer(16'd3, 60, -1, -1);
        n_tests++; if (loads !== 3) begin n_fail++; $display("FAIL t2_loads got %0d want 3", loads); end
        n_tests++; if ({base_at_load[0], base_at_load[1], base_at_load[2]} !== {16'd0, 16'd2, 16'd2})
            begin n_fail++; $display("FAIL t2_bases got %0d,%0d,%0d want 0,2,2", base_at_load[0], base_at_load[1], base_at_load[2]); end
        n_tests++; if ({adds_at_load[0], adds_at_load[1], adds_at_load[2]} !== {16'd2, 16'd0, 16'd5})
            begin n_fail++; $display("FAIL t2_adds got %0d,%0d,%0d want 2,0,5", adds_at_load[0], adds_at_load[1], adds_at_load[2]); end
        n_tests++; if (fetch_n1 !== 0) begin n_fail++; $display("FAIL t2_n1_fetch got %0d want 0", fetch_n1); end
        n_tests++; if (fetches !== 7) begin n_fail++; $display("FAIL t2_fetches got %0d want 7", fetches); end
        n_tests++; if (commits !== 3) begin n_fail++; $display("FAIL t2_commits got %0d want 3", commits); end
        n_tests++; if (done_cyc !== 26) begin n_fail++; $display("FAIL t2_done_cyc got %0d want 26", done_cyc); end
        n_tests++; if (bus.pf_base !== 16'd7) begin n_fail++; $display("FAIL t2_base got %0d want 7", bus.pf_base); end
        cyc();
    endtask

    task automatic test_zero();
        run_layer(16'd0, 10, -1, -1);
        n_tests++; if (done_cyc !== 1) begin n_fail++; $display("FAIL t3_done_cyc got %0d want 1", done_cyc); end
        n_tests++; if ({loads, clears} !== {32'd0, 32'd0}) begin n_fail++; $display("FAIL t3_load_clear got %0d/%0d want 0/0", loads, clears); end
        cyc();
    endtask

    // Neuron 0 (1 add) ends at cycle 8; neuron 1 (8 adds) fetches from cycle 12.
    task automatic test_abort();
        rom[0] = 16'd1; rom[1] = 16'd8;
        run_layer(16'd2, 30, -1, 13);
        n_tests++; if (ab_pre_fetch !== 1'b1) begin n_fail++; $display("FAIL t4_pre_fetch got %b want 1", ab_pre_fetch); end
        n_tests++; if ({ab_fetch, ab_busy} !== 2'b00) begin n_fail++; $display("FAIL t4_after fetch=%b busy=%b want 0/0", ab_fetch, ab_busy); end
        n_tests++; if ({ab_idx, ab_base} !== {16'd1, 16'd1}) begin n_fail++; $display("FAIL t4_hold idx=%0d base=%0d want 1/1", ab_idx, ab_base); end
        n_tests++; if (done_cyc !== -1) begin n_fail++; $display("FAIL t4_no_done got %0d want -1", done_cyc); end
        run_layer(16'd1, 30, -1, -1);
        n_tests++; if ({idx_c1, base_c1} !== {16'd0, 16'd0}) begin n_fail++; $display("FAIL t4_restart idx=%0d base=%0d want 0/0", idx_c1, base_c1); end
        n_tests++; if (done_cyc !== 9) begin n_fail++; $display("FAIL t4_restart_done got %0d want 9", done_cyc); end
        cyc();
    endtask

    task automatic test_rst_and_busy_start();
        rom[0] = 16'd4;
        bus.num_neurons = 16'd1;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        repeat (8) cyc();
        n_tests++; if ({bus.busy, bus.pf_start_fetch, bus.mac_commit} !== 3'b100)
            begin n_fail++; $display("FAIL t5_in_drain busy/fetch/commit=%b want 100", {bus.busy, bus.pf_start_fetch, bus.mac_commit}); end
        #2 rst = 1'b0;
        #1;
        n_tests++; if (outs !== '0) begin n_fail++; $display("FAIL t5_async_rst got %h want 0", outs); end
        rst = 1'b1;
        cyc();
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL t5_idle busy=%b want 0", bus.busy); end
        repeat (4) cyc();
        run_layer(16'd1, 40, 3, -1);
        n_tests++; if ({loads, done_cyc} !== {32'd1, 32'd12}) begin n_fail++; $display("FAIL t5_busy_start loads=%0d done=%0d want 1/12", loads, done_cyc); end
        cyc();
    endtask

    task automatic test_we_check();
        logic exp_err;
`ifdef SEQ_WE_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        rom[0] = 16'd4;
        drop_first = 1'b1;
        run_layer(16'd1, 40, -1, -1);
        drop_first = 1'b0;
        n_tests++; if (err_done !== exp_err) begin n_fail++; $display("FAIL t6_err got %b want %b", err_done, exp_err); end
        cyc();
        n_tests++; if (bus.err !== exp_err) begin n_fail++; $display("FAIL t6_sticky got %b want %b", bus.err, exp_err); end
        repeat (3) cyc();
        run_layer(16'd1, 40, -1, -1);
        n_tests++; if ({err_c1, err_done} !== 2'b00) begin n_fail++; $display("FAIL t6_clear got %b/%b want 0/0", err_c1, err_done); end
        cyc();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.num_neurons = '0;
        for (int i = 0; i < 8; i++) rom[i] = '0;
        test_reset();
        test_single();
        test_multi();
        test_zero();
        test_abort();
        test_rst_and_busy_start();
        test_we_check();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
